// File: rtl/debug_pkg.sv
// debug_pkg: shared definitions for the UART debugger front end.
//   - command code constants and reply bytes (ACK / ERR)
//   - decoder state enum (S_CHK exists only when SDEC_CHECKSUM_EN is defined)
//   - helpers: needs_addr / needs_data / is_read / is_ctrl
package debug_pkg;

  localparam logic [3:0] CMD_PAUSE    = 4'h1;
  localparam logic [3:0] CMD_RESUME   = 4'h2;
  localparam logic [3:0] CMD_STEP     = 4'h3;
  localparam logic [3:0] CMD_RESET    = 4'h4;
  localparam logic [3:0] CMD_STATUS   = 4'h5;
  localparam logic [3:0] CMD_MEM_RD_B = 4'h6;
  localparam logic [3:0] CMD_MEM_RD_W = 4'h7;
  localparam logic [3:0] CMD_REG_RD   = 4'h8;
  localparam logic [3:0] CMD_BP_ADD   = 4'h9;
  localparam logic [3:0] CMD_BP_RM    = 4'hA;
  localparam logic [3:0] CMD_MEM_WR_B = 4'hB;
  localparam logic [3:0] CMD_MEM_WR_W = 4'hC;
  localparam logic [3:0] CMD_REG_WR   = 4'hD;

  localparam logic [7:0] REPLY_ACK = 8'hA5;
  localparam logic [7:0] REPLY_ERR = 8'hEE;

  typedef enum logic [2:0] {
    S_CMD   = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_REPLY = 3'd5
`ifdef SDEC_CHECKSUM_EN
    , S_CHK = 3'd6
`endif
  } state_t;

  function automatic logic needs_addr(input logic [3:0] code);
    return (code >= CMD_MEM_RD_B) && (code <= CMD_REG_WR);
  endfunction

  function automatic logic needs_data(input logic [3:0] code);
    return (code >= CMD_MEM_WR_B) && (code <= CMD_REG_WR);
  endfunction

  function automatic logic is_read(input logic [3:0] code);
    return (code >= CMD_MEM_RD_B) && (code <= CMD_REG_RD);
  endfunction

  // Address-less commands that still go to the controller.
  function automatic logic is_ctrl(input logic [3:0] code);
    return (code >= CMD_PAUSE) && (code <= CMD_STATUS);
  endfunction

endpackage

// File: rtl/byte_shift_reg32.sv
// byte_shift_reg32: 32-bit register that shifts in one byte per load, MSB
// first, with a 2-bit index of the byte position within the word.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : clear value and index
//   load       : shift byte_in into the low byte
//   byte_in    : incoming byte
//   q          : assembled word
//   idx        : number of bytes shifted in so far (mod 4)
module byte_shift_reg32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] q,
  output logic [1:0]  idx
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q   <= '0;
      idx <= '0;
    end else if (load) begin
      q   <= {q[23:0], byte_in};
      idx <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/serial_cmd_decoder.sv
// serial_cmd_decoder: assembles host byte frames (cmd, optional 4-byte
// address, optional 4-byte data) into a controller command, pulses in_valid,
// waits for the controller, then sends the reply bytes to the UART TX.
//
// Optional build macro: SDEC_CHECKSUM_EN -- frames carry a trailing XOR byte
// checked in S_CHK; a mismatch suppresses the command and replies 0xEE.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   rx_data, rx_valid   : received byte and its one-cycle strobe
//   tx_busy             : transmitter busy (rises the cycle after tx_start)
//   tx_data, tx_start   : byte to transmit and its one-cycle strobe
//   cmd, addr, data     : command to controller
//   in_valid            : one-cycle command strobe
//   ctrlr_busy, error   : controller status (busy includes in_valid)
//   rd_data             : controller read result, valid when busy falls
module serial_cmd_decoder
  import debug_pkg::*;
#(
  parameter int CLK_RATE       = 50,
  parameter int GAP_TIMEOUT_US = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic [3:0]  cmd,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic        in_valid,
  input  logic        ctrlr_busy,
  input  logic        error,
  input  logic [31:0] rd_data
);

  localparam int GAP_CYCLES = GAP_TIMEOUT_US * CLK_RATE;
  localparam int GAP_W      = $clog2(GAP_CYCLES + 1);

`ifdef SDEC_CHECKSUM_EN
  localparam state_t FRAME_END = S_CHK;
`else
  localparam state_t FRAME_END = S_ISSUE;
`endif

  state_t             state_q, state_d;
  logic [3:0]         cmd_q;
  logic [GAP_W-1:0]   gap_q;
  logic               gap_expired;
  logic               wait_first_q;
  logic               guard_q;
  logic [1:0]         rem_q;
  logic [31:0]        reply_q;
  logic [1:0]         addr_idx, data_idx;

  logic               cmd_ld, fld_clr, addr_ld, data_ld;
  logic               rep_ld, rep_shift, tx_fire, gap_run;
  logic [31:0]        rep_word;
  logic [1:0]         rep_rem;

`ifdef SDEC_CHECKSUM_EN
  logic [7:0]         chk_q;
`endif

  assign cmd         = cmd_q;
  assign gap_expired = (gap_q == GAP_W'(GAP_CYCLES));

  byte_shift_reg32 u_addr (
    .clk     (clk),
    .rst     (rst),
    .clr     (fld_clr),
    .load    (addr_ld),
    .byte_in (rx_data),
    .q       (addr),
    .idx     (addr_idx)
  );

  byte_shift_reg32 u_data (
    .clk     (clk),
    .rst     (rst),
    .clr     (fld_clr),
    .load    (data_ld),
    .byte_in (rx_data),
    .q       (data),
    .idx     (data_idx)
  );

  always_comb begin
    state_d   = state_q;
    cmd_ld    = 1'b0;
    fld_clr   = 1'b0;
    addr_ld   = 1'b0;
    data_ld   = 1'b0;
    rep_ld    = 1'b0;
    rep_word  = '0;
    rep_rem   = '0;
    rep_shift = 1'b0;
    tx_fire   = 1'b0;
    gap_run   = 1'b0;
    in_valid  = 1'b0;
    tx_start  = 1'b0;
    tx_data   = '0;

    case (state_q)
      S_CMD: begin
        if (rx_valid) begin
          cmd_ld  = 1'b1;
          fld_clr = 1'b1;
          if (needs_addr(rx_data[3:0])) begin
            state_d = S_ADDR;
          end else if (is_ctrl(rx_data[3:0])) begin
            state_d = FRAME_END;
          end else begin
            // Unknown code: reject without bothering the controller.
            state_d  = S_REPLY;
            rep_ld   = 1'b1;
            rep_word = {REPLY_ERR, 24'h0};
          end
        end
      end

      S_ADDR: begin
        gap_run = 1'b1;
        if (rx_valid) begin
          addr_ld = 1'b1;
          if (addr_idx == 2'd3)
            state_d = needs_data(cmd_q) ? S_DATA : FRAME_END;
        end else if (gap_expired) begin
          state_d = S_CMD;
        end
      end

      S_DATA: begin
        gap_run = 1'b1;
        if (rx_valid) begin
          data_ld = 1'b1;
          if (data_idx == 2'd3)
            state_d = FRAME_END;
        end else if (gap_expired) begin
          state_d = S_CMD;
        end
      end

`ifdef SDEC_CHECKSUM_EN
      S_CHK: begin
        gap_run = 1'b1;
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            state_d = S_ISSUE;
          end else begin
            state_d  = S_REPLY;
            rep_ld   = 1'b1;
            rep_word = {REPLY_ERR, 24'h0};
          end
        end else if (gap_expired) begin
          state_d = S_CMD;
        end
      end
`endif

      S_ISSUE: begin
        in_valid = 1'b1;
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        // The first WAIT cycle still sees busy driven by our own in_valid.
        if (!wait_first_q && !ctrlr_busy) begin
          state_d = S_REPLY;
          rep_ld  = 1'b1;
          if (is_read(cmd_q) && !error) begin
            rep_word = (cmd_q == CMD_MEM_RD_B) ? {24'h0, rd_data[7:0]} : rd_data;
            rep_rem  = 2'd3;
          end else begin
            rep_word = {(error ? REPLY_ERR : REPLY_ACK), 24'h0};
          end
        end
      end

      S_REPLY: begin
        // Next byte always sits in the top byte of reply_q.
        tx_data = reply_q[31:24];
        if (!guard_q) begin
          if (!tx_busy) begin
            tx_start = 1'b1;
            tx_fire  = 1'b1;
          end
        end else if (rem_q == 2'd0) begin
          state_d = S_CMD;
        end else begin
          rep_shift = 1'b1;
        end
      end

      default: state_d = S_CMD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CMD;
      cmd_q        <= '0;
      gap_q        <= '0;
      wait_first_q <= 1'b0;
      guard_q      <= 1'b0;
      rem_q        <= '0;
    end else begin
      state_q      <= state_d;
      wait_first_q <= (state_q == S_ISSUE);
      guard_q      <= tx_fire;
      if (cmd_ld)
        cmd_q <= rx_data[3:0];
      if (!gap_run || rx_valid)
        gap_q <= '0;
      else if (!gap_expired)
        gap_q <= gap_q + GAP_W'(1);
      if (rep_ld)
        rem_q <= rep_rem;
      else if (rep_shift)
        rem_q <= rem_q - 2'd1;
    end
  end

  // Reply payload; only observed through tx_data while in S_REPLY.
  always_ff @(posedge clk) begin
    if (rep_ld)
      reply_q <= rep_word;
    else if (rep_shift)
      reply_q <= {reply_q[23:0], 8'h00};
  end

`ifdef SDEC_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (cmd_ld)
      chk_q <= rx_data;
    else if (addr_ld || data_ld)
      chk_q <= chk_q ^ rx_data;
  end
`endif

endmodule

// File: tb/tb_serial_cmd_decoder.sv
module tb_serial_cmd_decoder;

  localparam int CLK_RATE       = 1;
  localparam int GAP_TIMEOUT_US = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [3:0]  cmd;
  logic [31:0] addr;
  logic [31:0] data;
  logic        in_valid;
  logic        ctrlr_busy;
  logic        error;
  logic [31:0] rd_data;

  serial_cmd_decoder #(
    .CLK_RATE       (CLK_RATE),
    .GAP_TIMEOUT_US (GAP_TIMEOUT_US)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .cmd        (cmd),
    .addr       (addr),
    .data       (data),
    .in_valid   (in_valid),
    .ctrlr_busy (ctrlr_busy),
    .error      (error),
    .rd_data    (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] d;
  } iv_t;

  iv_t        exp_iv[$];
  logic [7:0] exp_tx[$];
  int vectors = 0;
  int miscompares = 0;

  // Controller model: busy for ctl_lat cycles after the command pulse.
  int          ctl_lat = 3;
  logic [31:0] ctl_rd  = '0;
  logic        ctl_err = 1'b0;
  int          busy_cnt = 0;
  always @(posedge clk) begin
    if (in_valid) busy_cnt <= ctl_lat;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign ctrlr_busy = in_valid || (busy_cnt != 0);
  assign rd_data    = ctl_rd;
  assign error      = ctl_err;

  // Transmitter model: busy from the cycle after tx_start for tx_lat cycles.
  int tx_lat = 4;
  int txb_cnt = 0;
  always @(posedge clk) begin
    if (tx_start) txb_cnt <= tx_lat;
    else if (txb_cnt > 0) txb_cnt <= txb_cnt - 1;
  end
  assign tx_busy = (txb_cnt != 0);

  // Reference model: what one frame should produce on each interface.
  function automatic void model_frame(input logic [7:0] cbyte, input logic [31:0] a,
                                      input logic [31:0] d, input logic [31:0] rd,
                                      input logic err);
    int code;
    logic [31:0] word;
    iv_t e;
    code = int'(cbyte[3:0]);
    if (code == 0 || code >= 14) begin
      exp_tx.push_back(8'hEE);
      return;
    end
    e.c = cbyte[3:0];
    e.a = (code >= 6) ? a : 32'h0;
    e.d = (code >= 11) ? d : 32'h0;
    exp_iv.push_back(e);
    if (code >= 6 && code <= 8 && !err) begin
      word = (code == 6) ? (rd % 256) : rd;
      for (int i = 3; i >= 0; i--) exp_tx.push_back(8'((word >> (8 * i)) % 256));
    end else begin
      exp_tx.push_back(err ? 8'hEE : 8'hA5);
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] cbyte, input logic [31:0] a,
                            input logic [31:0] d, input int max_gap);
    logic [7:0] bytes[$];
    int code;
    code = int'(cbyte[3:0]);
    bytes.push_back(cbyte);
    if (code >= 6 && code <= 13)
      for (int i = 3; i >= 0; i--) bytes.push_back(8'((a >> (8 * i)) % 256));
    if (code >= 11 && code <= 13)
      for (int i = 3; i >= 0; i--) bytes.push_back(8'((d >> (8 * i)) % 256));
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_iv.size() != 0 || exp_tx.size() != 0 || tx_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 3000) begin
      miscompares++;
      $display("FAIL %s idle: pending in_valid=%0d tx=%0d, required 0 0",
               tag, exp_iv.size(), exp_tx.size());
      exp_iv.delete();
      exp_tx.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic run_txn(input string tag, input logic [7:0] cbyte, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rd, input logic err,
                         input int lat, input int max_gap);
    ctl_rd  = rd;
    ctl_err = err;
    ctl_lat = lat;
    model_frame(cbyte, a, d, rd, err);
    send_frame(cbyte, a, d, max_gap);
    wait_idle(tag);
  endtask

  task automatic check_zero(input string tag);
    vectors++;
    if (tx_data !== 8'h00 || tx_start !== 1'b0 || cmd !== 4'h0 || addr !== 32'h0 ||
        data !== 32'h0 || in_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s outputs: tx_data=%h tx_start=%b cmd=%h addr=%h data=%h in_valid=%b, required all 0",
               tag, tx_data, tx_start, cmd, addr, data, in_valid);
    end
  endtask

  task automatic monitor();
    iv_t e;
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      if (!rst && in_valid) begin
        vectors++;
        if (exp_iv.size() == 0) begin
          miscompares++;
          $display("FAIL in_valid unexpected: cmd=%h addr=%h data=%h, required no pulse",
                   cmd, addr, data);
        end else begin
          e = exp_iv.pop_front();
          if (cmd !== e.c || addr !== e.a || data !== e.d) begin
            miscompares++;
            $display("FAIL command: cmd=%h addr=%h data=%h, required cmd=%h addr=%h data=%h",
                     cmd, addr, data, e.c, e.a, e.d);
          end
        end
      end
      if (!rst && tx_start) begin
        vectors++;
        if (exp_tx.size() == 0) begin
          miscompares++;
          $display("FAIL tx_start unexpected: tx_data=%h, required no pulse", tx_data);
        end else begin
          eb = exp_tx.pop_front();
          if (tx_data !== eb) begin
            miscompares++;
            $display("FAIL tx byte: tx_data=%h, required %h", tx_data, eb);
          end
        end
      end
    end
  endtask

  initial begin
    int n;
    logic [3:0] code;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("idle_after_reset");

    tx_lat = 4;
    run_txn("rd_word", 8'h07, 32'h0000_1000, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);
    run_txn("wr_word", 8'h0C, 32'h0000_0020, 32'h1234_5678, 32'h0, 1'b0, 2, 0);
    run_txn("pause_err", 8'h01, 32'h0, 32'h0, 32'h0, 1'b1, 3, 0);
    run_txn("bad_code", 8'h0F, 32'h0, 32'h0, 32'h0, 1'b0, 3, 0);
    run_txn("rd_byte", 8'h36, 32'hAABB_CCDD, 32'h0, 32'h1122_3344, 1'b0, 1, 2);

    // Partial frame then silence past the gap timeout: nothing may come out.
    send_byte(8'h08);
    send_byte(8'h00);
    repeat (4 * GAP_TIMEOUT_US * CLK_RATE) @(negedge clk);
    run_txn("after_gap", 8'h05, 32'h0, 32'h0, 32'h0, 1'b0, 3, 0);

    // Reset during a 4-byte reply, right after the first byte goes out.
    ctl_rd = 32'hCAFE_F00D; ctl_err = 1'b0; ctl_lat = 2; tx_lat = 4;
    exp_iv.push_back('{c: 4'h7, a: 32'h0, d: 32'h0});
    exp_tx.push_back(8'hCA);
    send_frame(8'h07, 32'h0, 32'h0, 0);
    n = 0;
    while (exp_tx.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid_reply_reset");
    rst = 1'b0;
    repeat (30) @(negedge clk);
    vectors++;
    if (exp_tx.size() != 0 || exp_iv.size() != 0) begin
      miscompares++;
      $display("FAIL mid_reply_pending: tx=%0d in_valid=%0d, required 0 0",
               exp_tx.size(), exp_iv.size());
      exp_tx.delete();
      exp_iv.delete();
    end
    wait_idle("post_reset");

    for (int t = 0; t < 60; t++) begin
      code = 4'($urandom_range(15, 0));
      tx_lat = $urandom_range(5, 1);
      run_txn("random", {4'($urandom_range(15, 0)), code}, $urandom, $urandom, $urandom,
              ($urandom_range(3, 0) == 0), $urandom_range(6, 1), 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_cmd_decoder.md
Name: serial_cmd_decoder

Overview:
- Front end of the UART debugger, sitting between the UART byte receiver/transmitter and the controller FSM.
- Assembles host byte frames into a command code, a 32-bit address and 32-bit write data, then issues them to the controller with a one-cycle valid pulse.
- Waits for the controller to finish, then transmits the reply bytes (read data or an ack/error byte) back to the host.

Parameters:
- CLK_RATE, 50, clock rate in MHz.
- GAP_TIMEOUT_US, 1000, maximum idle time between bytes of one frame, in µs; after it the partial frame is discarded.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data valid.
- tx_busy  in  1  transmitter busy; it rises the cycle after tx_start.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle transmit strobe.
- cmd  out  4  command code to controller.
- addr  out  32  address / register index / breakpoint slot.
- data  out  32  write data.
- in_valid  out  1  one-cycle command strobe to controller.
- ctrlr_busy  in  1  controller busy; combinationally includes in_valid.
- error  in  1  controller timeout flag, registered.
- rd_data  in  32  MCU read result, valid when ctrlr_busy falls.

Behaviour:
- Reset: all outputs 0; state S_CMD; counters 0. Reset in any state aborts the frame or reply with no further tx_start or in_valid.
- Command codes: 0x1 pause, 0x2 resume, 0x3 step, 0x4 reset, 0x5 status, 0x6 mem rd byte, 0x7 mem rd word, 0x8 reg rd, 0x9 bp add, 0xA bp rm, 0xB mem wr byte, 0xC mem wr word, 0xD reg wr.
- Frame format: cmd byte (low nibble = code, high nibble ignored), then optional address bytes, then optional data bytes.
  - Address present for 0x6–0xD: 4 bytes.
  - Data present for 0xB, 0xC, 0xD: 4 bytes.
  - Multi-byte fields are MSB first and shifted in as {field[23:0], rx_data}.
- S_CMD: on rx_valid, latch the code and clear addr/data. Then:
  - code needs an address → S_ADDR;
  - code is 0x1–0x5 → S_ISSUE;
  - code is 0x0, 0xE or 0xF → S_REPLY with byte 0xEE; no in_valid is issued.
- S_ADDR / S_DATA: a 2-bit index counts 4 bytes. On the 4th byte, go to S_DATA if data is needed, else S_ISSUE.
- Gap timer: cleared on every rx_valid and runs only in S_ADDR/S_DATA. When it reaches GAP_TIMEOUT_US*CLK_RATE, return to S_CMD silently; no reply is sent.
- S_ISSUE: in_valid=1 for exactly one cycle, with cmd/addr/data stable, then → S_WAIT.
- S_WAIT:
  - Ignore the first cycle, since ctrlr_busy is still high from the pulse.
  - Afterwards, on ctrlr_busy==0, capture rd_data and error → S_REPLY.
  - rx bytes arriving in S_ISSUE, S_WAIT or S_REPLY are dropped; the host is half-duplex.
- S_REPLY:
  - Reply is 4 bytes of rd_data, MSB first, for codes 0x6/0x7/0x8 with no error; otherwise 1 byte: 0xA5 ack, or 0xEE if error was captured.
  - Byte 0x6 read replies {24'h0, rd_data[7:0]} in the same 4-byte format.
  - For each byte: wait for tx_busy==0, pulse tx_start with tx_data stable, skip one guard cycle, repeat.
  - After the last byte is accepted → S_CMD.
- Worst-case latency from cmd byte to in_valid: 1 cycle after the final frame byte.

Optional Feature:
- SDEC_CHECKSUM_EN defined:
  - Every frame carries a trailing byte equal to the XOR of all preceding frame bytes, checked in state S_CHK.
  - The gap timer also runs in S_CHK.
  - On mismatch: no in_valid, reply 0xEE.
- SDEC_CHECKSUM_EN undefined: no trailing byte; S_CHK and the XOR accumulator are absent.

Decomposition:
- Package debug_pkg holds the command code localparams, reply constants (ACK 0xA5, ERR 0xEE), the state enum, and the functions needs_addr(code), needs_data(code) and is_read(code).
- Sub-module byte_shift_reg32 (32-bit shift-in register with load/clear and 2-bit byte index) is instantiated twice, once for addr and once for data.

Test Plan:
- Bytes 0x07,0x00,0x00,0x10,0x00; controller busy 3 cycles; rd_data=0xDEADBEEF → one in_valid pulse with cmd=7, addr=0x1000; tx bytes DE,AD,BE,EF.
- Bytes 0x0C,0x00,0x00,0x00,0x20,0x12,0x34,0x56,0x78 → cmd=C, addr=0x20, data=0x12345678; reply A5.
- Byte 0x01; controller error=1 when busy falls → reply EE.
- Byte 0x0F → no in_valid; reply EE.
- Bytes 0x08,0x00 then silence > GAP_TIMEOUT → no in_valid, no tx; next 0x05 → in_valid cmd=5, reply A5.
- rst asserted mid-reply after the first byte of a 4-byte read → no further tx_start; all outputs 0 the next cycle.
